// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys_pkg
//  Purpose  : Shared types and constants for the TTC-style serial link shell.
//             Holds the TX/RX state encodings, frame constants and the frame
//             parity helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sys_pkg;

  // Frame is start, T, C, P sent in that order.
  localparam int   FRAME_LEN = 4;
  localparam logic START_BIT = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HUNT = 2'd0,
    RX_T    = 2'd1,
    RX_C    = 2'd2,
    RX_P    = 2'd3
  } rx_state_t;

  // Parity bit chosen so the whole frame (start bit included) has an odd
  // number of ones.
  function automatic logic frame_parity(input logic t, input logic c);
    return t ^ c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttc_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ttc_rx
//  Purpose  : Serial frame receiver. Hunts for a start bit, captures T and C,
//             checks parity on P and, for a good frame, pulses o_trig with T
//             for one cycle and holds o_cmd at C until the next good frame.
//  Config   : DIFF_CHECK_EN - when defined, i_data_p == i_data_n inside a
//             frame aborts it; when undefined i_data_n is ignored.
//  Ports    : clk      in  clock, one serial bit per cycle
//             rst      in  synchronous reset, active low
//             i_data_p in  serial line, true side
//             i_data_n in  serial line, complement side
//             o_trig   out one-cycle trigger pulse
//             o_cmd    out held command level
//  Revision : 1.0 - initial release
// ============================================================================
module ttc_rx
  import sys_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_data_p,
  input  logic i_data_n,
  output logic o_trig,
  output logic o_cmd
);

  rx_state_t r_state;
  rx_state_t w_next;
  logic      r_t;
  logic      r_c;
  logic      r_trig;
  logic      r_cmd;
  logic      w_line_err;
  logic      w_frame_ok;

`ifdef DIFF_CHECK_EN
  assign w_line_err = (i_data_p == i_data_n);
`else
  logic w_unused_n;
  assign w_line_err = 1'b0;
  assign w_unused_n = i_data_n;
`endif

  // Parity is compared on the same edge that samples P.
  assign w_frame_ok = (r_state == RX_P) && !w_line_err &&
                      (i_data_p == frame_parity(r_t, r_c));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RX_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a line error inside a frame drops straight to HUNT,
  // while in HUNT it is simply not a start bit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_HUNT: if (i_data_p && !w_line_err) w_next = RX_T;
      RX_T:    w_next = w_line_err ? RX_HUNT : RX_C;
      RX_C:    w_next = w_line_err ? RX_HUNT : RX_P;
      RX_P:    w_next = RX_HUNT;
      default: w_next = RX_HUNT;
    endcase
  end

  // Captured bits and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_t    <= 1'b0;
      r_c    <= 1'b0;
      r_trig <= 1'b0;
      r_cmd  <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      if (r_state == RX_T) r_t <= i_data_p;
      if (r_state == RX_C) r_c <= i_data_p;
      if (w_frame_ok) begin
        r_trig <= r_t;
        r_cmd  <= r_c;
      end
    end
  end

  assign o_trig = r_trig;
  assign o_cmd  = r_cmd;

endmodule
`default_nettype wire

// File: rtl/sys_top.sv
`default_nettype none
// ============================================================================
//  Module   : sys_top
//  Purpose  : Emulation shell for a serial TTC-style link. Encodes trigger /
//             command requests into 4-bit frames (start, T, C, P) followed by
//             GAP idle bits, and decodes received frames via ttc_rx.
//  Config   : DIFF_CHECK_EN - enables differential line-error checking in RX.
//  Params   : GAP - idle bits after each frame, 1..15
//  Ports    : clkin40     in  clock, one serial bit per cycle
//             rst         in  synchronous reset, active low
//             trigger     in  trigger request
//             command     in  command request
//             ttc_data_p  in  RX line, true side
//             ttc_data_n  in  RX line, complement side
//             dataout_p   out TX line, true side (registered)
//             dataout_n   out TX line, complement side
//             trig_out    out one-cycle pulse per good frame with T=1
//             cmd_out_p   out C of last good frame
//             cmd_out_n   out complement of cmd_out_p
//  Revision : 1.0 - initial release
// ============================================================================
module sys_top
  import sys_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic clkin40,
  input  logic rst,
  input  logic trigger,
  input  logic command,
  input  logic ttc_data_p,
  input  logic ttc_data_n,
  output logic dataout_p,
  output logic dataout_n,
  output logic trig_out,
  output logic cmd_out_p,
  output logic cmd_out_n
);

  tx_state_t              r_tx_state;
  tx_state_t              w_tx_next;
  logic                   r_pend_t;
  logic                   r_pend_c;
  logic [FRAME_LEN-2:0]   r_shift;     // T, C, P still to go after start
  logic [1:0]             r_bit_cnt;
  logic [3:0]             r_gap_cnt;
  logic                   r_dout;
  logic                   w_load;
  logic                   w_tx_bit;
  logic                   w_send_last;
  logic                   w_gap_last;
  logic                   w_cmd;

  assign w_send_last = (r_bit_cnt == 2'(FRAME_LEN - 2));
  assign w_gap_last  = (r_gap_cnt == 4'(GAP - 1));

  // TX state register
  always_ff @(posedge clkin40) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  // TX next-state logic
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (r_pend_t || r_pend_c) w_tx_next = TX_SEND;
      TX_SEND: if (w_send_last)          w_tx_next = TX_GAP;
      TX_GAP:  if (w_gap_last)           w_tx_next = TX_IDLE;
      default:                           w_tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: the start bit goes straight to the line on the load edge,
  // so the shift register only holds the remaining three bits.
  always_comb begin
    w_load   = 1'b0;
    w_tx_bit = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_load   = r_pend_t || r_pend_c;
        w_tx_bit = w_load ? START_BIT : 1'b0;
      end
      TX_SEND: w_tx_bit = r_shift[FRAME_LEN-2];
      default: w_tx_bit = 1'b0;
    endcase
  end

  // TX datapath and request capture
  always_ff @(posedge clkin40) begin
    if (!rst) begin
      r_pend_t  <= 1'b0;
      r_pend_c  <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_dout    <= 1'b0;
    end else begin
      r_dout <= w_tx_bit;
      // A request sampled on the load edge lands in the next frame.
      r_pend_t <= (w_load ? 1'b0 : r_pend_t) | trigger;
      r_pend_c <= (w_load ? 1'b0 : r_pend_c) | command;
      if (w_load) begin
        r_shift   <= {r_pend_t, r_pend_c, frame_parity(r_pend_t, r_pend_c)};
        r_bit_cnt <= '0;
      end else if (r_tx_state == TX_SEND) begin
        r_shift   <= {r_shift[FRAME_LEN-3:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 2'd1;
      end
      if (r_tx_state == TX_SEND) begin
        r_gap_cnt <= '0;
      end else if (r_tx_state == TX_GAP) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end
    end
  end

  assign dataout_p = r_dout;
  assign dataout_n = ~r_dout;

  ttc_rx u_rx (
    .clk      (clkin40),
    .rst      (rst),
    .i_data_p (ttc_data_p),
    .i_data_n (ttc_data_n),
    .o_trig   (trig_out),
    .o_cmd    (w_cmd)
  );

  assign cmd_out_p = w_cmd;
  assign cmd_out_n = ~w_cmd;

endmodule
`default_nettype wire

// File: tb/tb_sys_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_top
//  Purpose  : Directed self-checking bench for sys_top (GAP = 2). Covers
//             reset, loopback frames, continuous requests, injected frames
//             and, with DIFF_CHECK_EN, differential line errors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sys_top;

  logic clkin40 = 1'b0;
  logic rst     = 1'b0;
  logic trigger = 1'b0;
  logic command = 1'b0;
  logic loop_en = 1'b1;
  logic inj_p   = 1'b0;
  logic inj_n   = 1'b1;
  logic ttc_data_p, ttc_data_n;
  logic dataout_p, dataout_n, trig_out, cmd_out_p, cmd_out_n;

  int n_cmp  = 0;
  int n_fail = 0;

  assign ttc_data_p = loop_en ? dataout_p : inj_p;
  assign ttc_data_n = loop_en ? dataout_n : inj_n;

  always #5 clkin40 = ~clkin40;

  sys_top #(.GAP(2)) dut (
    .clkin40    (clkin40),
    .rst        (rst),
    .trigger    (trigger),
    .command    (command),
    .ttc_data_p (ttc_data_p),
    .ttc_data_n (ttc_data_n),
    .dataout_p  (dataout_p),
    .dataout_n  (dataout_n),
    .trig_out   (trig_out),
    .cmd_out_p  (cmd_out_p),
    .cmd_out_n  (cmd_out_n)
  );

  task automatic step();
    @(posedge clkin40);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Request for one cycle in loopback, then check the transmitted bits and
  // the receive result five edges after the request edge.
  task automatic loop_frame(input logic t, input logic c, input logic [3:0] exp_bits,
                            input logic exp_trig, input logic exp_cmd);
    logic b;
    trigger = t;
    command = c;
    step();                      // edge 0
    trigger = 1'b0;
    command = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();                    // edges 1..4
      b = exp_bits[3-i];
      chk("tx_bit_p", dataout_p, b);
      chk("tx_bit_n", dataout_n, ~b);
      chk("trig_early", trig_out, 1'b0);
    end
    step();                      // edge 5
    chk("trig_pulse", trig_out, exp_trig);
    chk("cmd_p", cmd_out_p, exp_cmd);
    chk("cmd_n", cmd_out_n, ~exp_cmd);
    chk("gap0", dataout_p, 1'b0);
    step();                      // edge 6
    chk("trig_end", trig_out, 1'b0);
    chk("gap1", dataout_p, 1'b0);
    chk("cmd_hold", cmd_out_p, exp_cmd);
  endtask

  // Drive a 4-bit frame on the RX pair; bad_idx selects a bit position
  // where ttc_data_n is forced equal to ttc_data_p (-1 for none).
  task automatic inject(input logic [3:0] bits, input int bad_idx,
                        input logic exp_trig, input logic exp_cmd);
    for (int i = 0; i < 4; i++) begin
      inj_p = bits[3-i];
      inj_n = (i == bad_idx) ? bits[3-i] : ~bits[3-i];
      step();
      if (i < 3) chk("inj_trig_early", trig_out, 1'b0);
    end
    chk("inj_trig", trig_out, exp_trig);
    chk("inj_cmd", cmd_out_p, exp_cmd);
    inj_p = 1'b0;
    inj_n = 1'b1;
    step();
    chk("inj_trig_end", trig_out, 1'b0);
    chk("inj_cmd_hold", cmd_out_p, exp_cmd);
  endtask

  initial begin
    logic exp_d, exp_t, exp_c;
    int   idx, pos;

    // Reset held with requests toggling
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      trigger = (i % 2 == 0);
      command = (i % 2 == 1);
      step();
      chk("rst_dout_p", dataout_p, 1'b0);
      chk("rst_dout_n", dataout_n, 1'b1);
      chk("rst_trig", trig_out, 1'b0);
      chk("rst_cmd_p", cmd_out_p, 1'b0);
      chk("rst_cmd_n", cmd_out_n, 1'b1);
    end
    trigger = 1'b0;
    command = 1'b0;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", dataout_p, 1'b0);
      chk("post_rst_trig", trig_out, 1'b0);
    end

    // Loopback: trigger only -> 1,1,0,1
    loop_frame(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0);
    // Loopback: trigger and command -> 1,1,1,0
    loop_frame(1'b1, 1'b1, 4'b1110, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cmd_held_p", cmd_out_p, 1'b1);
      chk("cmd_held_n", cmd_out_n, 1'b0);
    end

    // Trigger held for 30 cycles: starts at edges 1,7,...,31 and a pulse
    // four edges after each start; the first good frame clears cmd.
    trigger = 1'b1;
    step();                      // edge 0
    for (int e = 1; e <= 40; e++) begin
      step();
      idx   = (e - 1) / 6;
      pos   = (e - 1) % 6;
      exp_d = (idx <= 5) && (pos == 0 || pos == 1 || pos == 3);
      exp_t = (e >= 5) && ((e - 5) % 6 == 0) && ((e - 5) / 6 <= 5);
      exp_c = (e < 5);
      chk("cont_dout", dataout_p, exp_d);
      chk("cont_trig", trig_out, exp_t);
      chk("cont_cmd", cmd_out_p, exp_c);
      if (e == 29) trigger = 1'b0;
    end

    // Injected frames on the RX pair
    loop_en = 1'b0;
    inj_p   = 1'b0;
    inj_n   = 1'b1;
    step();
    step();
    inject(4'b1011, -1, 1'b0, 1'b1);   // T=0 C=1: cmd set, no pulse
    inject(4'b1100, -1, 1'b0, 1'b1);   // bad parity: discarded
    inject(4'b1101, -1, 1'b1, 1'b0);   // T=1 C=0: pulse, cmd cleared
`ifdef DIFF_CHECK_EN
    inject(4'b1110, 2, 1'b0, 1'b0);    // line error on C: dropped
    inject(4'b1110, -1, 1'b1, 1'b1);   // same frame clean: accepted
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_top.md
# sys_top

Emulation-shell top for a serial TTC-style trigger/command link. It encodes the `trigger` and `command` request inputs into 4-bit serial frames on the `dataout` differential pair. It decodes frames arriving on the `ttc_data` pair into a `trig_out` pulse and a held `cmd_out` differential level. In system tests `dataout` is looped back to `ttc_data`, so the block checks its own encoder.

## Interface
Parameters:
- `GAP`, default 2: number of idle (0) bits transmitted after every frame; legal range 1-15.

Ports:
- `clkin40`, in, 1: single clock; one serial bit per cycle; all logic in this domain.
- `rst`, in, 1: reset, synchronous, active-low.
- `trigger`, in, 1: trigger request, sampled each cycle.
- `command`, in, 1: command request, sampled each cycle.
- `ttc_data_p`, in, 1: serial receive line, true side.
- `ttc_data_n`, in, 1: serial receive line, complement side.
- `dataout_p`, out, 1: serial transmit line, true side.
- `dataout_n`, out, 1: serial transmit line, complement side; always `~dataout_p`.
- `trig_out`, out, 1: one-cycle pulse per valid received frame whose trig bit is 1.
- `cmd_out_p`, out, 1: cmd bit of the last valid received frame.
- `cmd_out_n`, out, 1: always `~cmd_out_p`.

## Operation
- **Frame format:** 4 bits sent in this order: start (1), T, C, P. P = T ^ C, which makes the count of ones in the frame odd. The line idles at 0.
- **Request capture:**
  - `trigger` high sets `pend_t`; `command` high sets `pend_c`.
  - New requests keep being OR-ed in while a frame or gap is in progress.
- **TX FSM:** states IDLE, SEND, GAP.
  - IDLE, with `pend_t` or `pend_c` set: load {1, `pend_t`, `pend_c`, parity} into the shift register, clear the pending flags, go to SEND.
  - If a request is sampled in the same cycle as the load, it re-sets its flag for the next frame.
  - SEND shifts out 4 bits, then goes to GAP.
  - GAP drives 0 for `GAP` cycles, then returns to IDLE.
  - `dataout_p` is registered.
- **RX FSM:** states HUNT, T, C, P; input is `ttc_data_p` sampled once per cycle.
  - HUNT to T on a sampled 1.
  - T and C store their bits, then advance.
  - In P, check parity, then return to HUNT.
  - On a parity match: `trig_out` <= T for one cycle, and `cmd_out_p` <= C (held until the next valid frame).
  - On a parity mismatch: frame discarded, outputs unchanged.
  - There is no re-hunt inside a frame.
- **Reset values** (reset aborts any frame mid-operation; the line is idle on the first cycle after reset):
  - `dataout_p`=0, `dataout_n`=1
  - `trig_out`=0
  - `cmd_out_p`=0, `cmd_out_n`=1
  - both FSMs in IDLE/HUNT, pending flags cleared.

## Timing
- A request sampled at edge 0 puts the start bit on `dataout_p` after edge 1, T after edge 2, C after edge 3, P after edge 4, and gap bits from edge 5.
- Earliest next start bit is after edge 5+`GAP`. Frame period is 4+`GAP` cycles (6 by default).
- RX registers outputs on the edge that samples P. With loopback, `trig_out` is high from edge 5 to edge 6, so loopback latency is 5 cycles.
- Continuous requests with `GAP`=2 give one frame every 6 cycles, with no request lost.

## Configuration
- `DIFF_CHECK_EN` defined:
  - any RX sample with `ttc_data_p == ttc_data_n` is a line error;
  - in T/C/P it aborts the frame (back to HUNT, no output update);
  - in HUNT it is ignored.
- `DIFF_CHECK_EN` undefined: `ttc_data_n` is unused and only `ttc_data_p` is sampled.

## Structure
- Package `sys_pkg` holds:
  - TX state enum (IDLE/SEND/GAP);
  - RX state enum (HUNT/T/C/P);
  - `FRAME_LEN`=4, `START_BIT`=1'b1;
  - the parity function.
- Sub-module `ttc_rx` holds the RX FSM and `cmd_out`/`trig_out` registers. The TX path and request capture stay inline in `sys_top`.

## Test plan
- Reset held for 4 cycles with `trigger`/`command` toggling: `dataout_p`=0, `dataout_n`=1, `trig_out`=0, `cmd_out_p`=0, `cmd_out_n`=1 throughout.
- Loopback, `trigger`=1 for one cycle at edge 0: `dataout_p` carries 1,1,0,1; `trig_out` pulses once after edge 5; `cmd_out_p` stays 0.
- Loopback, `trigger`=`command`=1 for one cycle: frame 1,1,1,0; `trig_out` pulse; `cmd_out_p`=1 and `cmd_out_n`=0, held after the requests drop.
- `trigger` held high for 30 cycles, `GAP`=2: a start bit every 6 cycles and one `trig_out` pulse per frame.
- Injected frame 1,1,0,0 (bad parity) on `ttc_data`: no `trig_out`, `cmd_out` unchanged.
- With `DIFF_CHECK_EN`, force `ttc_data_n`=`ttc_data_p` during the C bit of a valid frame: frame dropped, no `trig_out`.
